jump_fetch_unit: RTL and testbench
==================================

Name: jump_fetch_unit

Overview:
- PC register and IF/ID stage owner for the single-issue MIPS core.
- Consumes the decode-stage jump indication for the instruction held in IF/ID: `jump` plus `jump_addr_sel` (0 = J-type pseudo-direct target, 1 = JR register target).
- On a taken jump it redirects the PC and squashes the wrong-path instruction already fetched. No delay slot.
- Also handles hazard stalls, branch redirects, and a misaligned-JR check, and keeps a squash counter.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_WORD, 32'h0000_0000, instruction word inserted into IF/ID as a bubble
CNT_W, 16, width of the squash counter

Ports:
clk  input  1  core clock
rst  input  1  asynchronous active-high reset
stall  input  1  hazard unit: hold PC and IF/ID this cycle
jump  input  1  decode: instruction in IF/ID is a taken jump
jump_addr_sel  input  1  decode: 0 = J target, 1 = JR target; don't-care when jump=0
jump_index  input  26  instr[25:0] of the IF/ID instruction
jr_addr  input  32  rs value (already forwarded) for JR
branch_taken  input  1  decode: conditional branch in IF/ID is taken
branch_target  input  32  precomputed branch target
imem_addr  output  32  instruction memory address (= pc), combinational read
imem_rdata  input  32  instruction word at imem_addr, same cycle
ifid_instr  output  32  registered instruction to decode
ifid_pc4  output  32  registered PC+4 of ifid_instr
ifid_valid  output  1  0 = bubble
flush  output  1  combinational: redirect taken this cycle
misalign_err  output  1  registered 1-cycle pulse: JR target had addr[1:0] != 0
squash_cnt  output  CNT_W  count of squashed fetches, saturating

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - pc = RESET_PC
  - ifid_instr = NOP_WORD, ifid_pc4 = RESET_PC, ifid_valid = 0
  - misalign_err = 0, squash_cnt = 0
- Redirect qualification: `redirect = ifid_valid & (jump | branch_taken)`. Inputs for an invalid IF/ID entry are ignored.
- Next-PC priority, evaluated only when `stall = 0`:
  1. jump & !jump_addr_sel → `{ifid_pc4[31:28], jump_index, 2'b00}`
  2. jump & jump_addr_sel → `{jr_addr[31:2], 2'b00}`
  3. branch_taken → `branch_target`
  4. otherwise → `pc + 4`, wrapping modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
- jump has priority over branch_taken when both are asserted.
- jump_addr_sel is never allowed to propagate X into pc when jump = 0.
- IF/ID update when `stall = 0`:
  - redirect: load bubble (NOP_WORD, valid = 0, ifid_pc4 unchanged); flush = 1.
  - no redirect: ifid_instr = imem_rdata, ifid_pc4 = pc + 4, valid = 1.
- Stall:
  - pc, IF/ID, squash_cnt and misalign_err hold; flush = 0. Stall wins over a simultaneous jump.
  - The jump is re-evaluated the cycle stall drops, because IF/ID still holds it.
- Redirect latency:
  - Jump seen in cycle N (no stall) → pc = target at cycle N+1.
  - The target instruction is valid in IF/ID at N+2.
  - Exactly one bubble per jump.
- misalign_err pulses for one cycle, in the cycle after a non-stalled JR redirect with jr_addr[1:0] != 0. The PC is still forced to the aligned address.
- squash_cnt increments by 1 on every non-stalled redirect and saturates at all-ones.
- A back-to-back jump cannot occur, since the bubble has valid = 0.
- Reset asserted mid-stall or mid-redirect overrides everything.
- Release of reset is synchronous to the clk edge after deassertion.
- Fetch resumes from RESET_PC with one cycle of valid = 0.

Decomposition:
- Shared core package:
  - opcode/funct constants (J = 6'b000010, SPECIAL = 6'b000000, JR funct = 6'b001000)
  - NOP_WORD
  - jump_addr_sel encoding names (SEL_J = 0, SEL_JR = 1)
- One natural sub-module: `next_pc_mux`, combinational, covering the priority select, J-target concatenation and JR alignment masking.
- The registers and counter stay in the top.

Test Plan:
- Reset then 3 unstalled cycles with imem returning 32'h1111_1111 → imem_addr = 0, 4, 8; ifid_valid 0 then 1; ifid_pc4 = 4 then 8.
- J with ifid_pc4 = 32'h4000_0010, jump_index = 26'h000_0040 → flush = 1; next imem_addr = 32'h4000_0100; one bubble; squash_cnt = 1.
- JR with jr_addr = 32'h0000_2002 → pc = 32'h0000_2000; misalign_err = 1 for exactly one cycle.
- stall = 1 together with jump for 3 cycles → pc and IF/ID unchanged, flush = 0. Stall drops → redirect occurs once; squash_cnt increments by 1 only.
- jump = 0, jump_addr_sel = X, branch_taken = 1, branch_target = 32'h0000_0080 → pc = 32'h80 with no X. jump and branch together → jump target wins.
- pc = 32'hFFFF_FFFC with no redirect → wraps to 0. Assert rst mid-run → outputs return to reset values asynchronously, before the next clk edge.

Source files
------------

// File: rtl/jump_fetch_unit_pkg.sv
// Shared core constants and types for the fetch front end: opcodes, the bubble
// word, the jump-select encoding and the redirect request bundle.
package jump_fetch_unit_pkg;

    localparam logic [5:0]  OP_J       = 6'b000010;
    localparam logic [5:0]  OP_SPECIAL = 6'b000000;
    localparam logic [5:0]  FUNCT_JR   = 6'b001000;
    localparam logic [31:0] CORE_NOP   = 32'h0000_0000;

    typedef enum logic {
        SEL_J  = 1'b0,
        SEL_JR = 1'b1
    } jsel_e;

    typedef struct packed {
        logic        jump;
        jsel_e       sel;
        logic [25:0] jump_index;
        logic [31:0] jr_addr;
        logic        branch;
        logic [31:0] branch_target;
    } redirect_req_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
    } ifid_t;

    // Pseudo-direct J target: region bits come from the delay-slot-free PC+4.
    function automatic logic [31:0] j_target(input logic [31:0] pc4,
                                             input logic [25:0] index);
        return {pc4[31:28], index, 2'b00};
    endfunction

endpackage

// File: rtl/jump_fetch_unit_if.sv
// Fetch/decode/imem bundle between the core and the jump fetch unit.
interface jump_fetch_unit_if #(parameter int CNT_W = 16);

    logic             stall;
    logic             jump;
    logic             jump_addr_sel;
    logic [25:0]      jump_index;
    logic [31:0]      jr_addr;
    logic             branch_taken;
    logic [31:0]      branch_target;
    logic [31:0]      imem_addr;
    logic [31:0]      imem_rdata;
    logic [31:0]      ifid_instr;
    logic [31:0]      ifid_pc4;
    logic             ifid_valid;
    logic             flush;
    logic             misalign_err;
    logic [CNT_W-1:0] squash_cnt;

    modport slave (
        input  stall, jump, jump_addr_sel, jump_index, jr_addr,
               branch_taken, branch_target, imem_rdata,
        output imem_addr, ifid_instr, ifid_pc4, ifid_valid,
               flush, misalign_err, squash_cnt
    );

    modport master (
        output stall, jump, jump_addr_sel, jump_index, jr_addr,
               branch_taken, branch_target, imem_rdata,
        input  imem_addr, ifid_instr, ifid_pc4, ifid_valid,
               flush, misalign_err, squash_cnt
    );

endinterface

// File: rtl/jump_fetch_unit_next_pc_mux.sv
// Next-PC select: jump beats branch beats sequential; JR target is force-aligned.
module next_pc_mux
    import jump_fetch_unit_pkg::*;
(
    input  logic [31:0]   pc4,
    input  logic [31:0]   ifid_pc4,
    input  redirect_req_t req,
    output logic [31:0]   next_pc,
    output logic          misalign
);

    // sel is only looked at under jump so an X on it cannot reach the PC.
    always_comb begin
        next_pc  = pc4;
        misalign = 1'b0;
        if (req.jump) begin
            if (req.sel == SEL_JR) begin
                next_pc  = {req.jr_addr[31:2], 2'b00};
                misalign = |req.jr_addr[1:0];
            end else begin
                next_pc  = j_target(ifid_pc4, req.jump_index);
            end
        end else if (req.branch) begin
            next_pc = req.branch_target;
        end
    end

endmodule

// File: rtl/jump_fetch_unit.sv
// PC register and IF/ID owner: redirects on jump/branch with one bubble,
// honours hazard stalls, flags misaligned JR and counts squashed fetches.
module jump_fetch_unit
    import jump_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = CORE_NOP,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    jump_fetch_unit_if.slave bus
);

    logic [31:0]      pc;
    logic [31:0]      pc4;
    logic [31:0]      next_pc;
    ifid_t            ifid;
    logic [CNT_W-1:0] squash_cnt;
    logic             misalign_err;
    logic             misalign_nxt;
    logic             redirect;
    redirect_req_t    req;

    // Decode indications are meaningless for a bubble, so qualify them here.
    always_comb begin
        req.jump          = ifid.valid & bus.jump;
        req.sel           = jsel_e'(bus.jump_addr_sel);
        req.jump_index    = bus.jump_index;
        req.jr_addr       = bus.jr_addr;
        req.branch        = ifid.valid & bus.branch_taken;
        req.branch_target = bus.branch_target;
    end

    assign redirect = req.jump | req.branch;
    assign pc4      = pc + 32'd4;

    next_pc_mux u_next_pc_mux (
        .pc4      (pc4),
        .ifid_pc4 (ifid.pc4),
        .req      (req),
        .next_pc  (next_pc),
        .misalign (misalign_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc           <= RESET_PC;
            ifid.instr   <= NOP_WORD;
            ifid.pc4     <= RESET_PC;
            ifid.valid   <= 1'b0;
            misalign_err <= 1'b0;
            squash_cnt   <= '0;
        end else if (!bus.stall) begin
            pc <= next_pc;
            if (redirect) begin
                ifid.instr   <= NOP_WORD;
                ifid.valid   <= 1'b0;
                misalign_err <= misalign_nxt;
                if (squash_cnt != '1)
                    squash_cnt <= squash_cnt + 1'b1;
            end else begin
                ifid.instr   <= bus.imem_rdata;
                ifid.pc4     <= pc4;
                ifid.valid   <= 1'b1;
                misalign_err <= 1'b0;
            end
        end
    end

    assign bus.imem_addr    = pc;
    assign bus.ifid_instr   = ifid.instr;
    assign bus.ifid_pc4     = ifid.pc4;
    assign bus.ifid_valid   = ifid.valid;
    assign bus.flush        = redirect & ~bus.stall;
    assign bus.misalign_err = misalign_err;
    assign bus.squash_cnt   = squash_cnt;

endmodule

// File: tb/tb_jump_fetch_unit.sv
// Directed vector bench for jump_fetch_unit plus a narrow-counter instance
// that exercises squash counter saturation.
module tb_jump_fetch_unit;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    jump_fetch_unit_if #(.CNT_W(16)) bus ();
    jump_fetch_unit_if #(.CNT_W(2))  bus2 ();

    jump_fetch_unit #(.CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));
    jump_fetch_unit #(.CNT_W(2))  dut2 (.clk(clk), .rst(rst), .bus(bus2));

    typedef struct {
        logic        stall;
        logic        jump;
        logic        sel;
        logic [25:0] idx;
        logic [31:0] jr;
        logic        br;
        logic [31:0] bt;
        logic [31:0] rdata;
        logic        e_flush;
        logic [31:0] e_pc;
        logic        e_valid;
        logic [31:0] e_pc4;
        logic [31:0] e_instr;
        logic [15:0] e_cnt;
        logic        e_mis;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic st, input logic j, input logic s, input logic [25:0] ix,
                       input logic [31:0] jr, input logic br, input logic [31:0] bt,
                       input logic [31:0] rd, input logic fl, input logic [31:0] pc,
                       input logic v, input logic [31:0] p4, input logic [31:0] ins,
                       input logic [15:0] cnt, input logic mis);
        vec_t t;
        t = '{st, j, s, ix, jr, br, bt, rd, fl, pc, v, p4, ins, cnt, mis};
        vq.push_back(t);
    endtask

    task automatic idle_inputs();
        bus.stall = 0; bus.jump = 0; bus.jump_addr_sel = 0; bus.jump_index = '0;
        bus.jr_addr = '0; bus.branch_taken = 0; bus.branch_target = '0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_imem_addr"}, bus.imem_addr, 32'h0);
        chk({tag, "_ifid_valid"}, {31'b0, bus.ifid_valid}, 32'h0);
        chk({tag, "_ifid_pc4"}, bus.ifid_pc4, 32'h0);
        chk({tag, "_ifid_instr"}, bus.ifid_instr, 32'h0);
        chk({tag, "_squash_cnt"}, {16'b0, bus.squash_cnt}, 32'h0);
        chk({tag, "_misalign"}, {31'b0, bus.misalign_err}, 32'h0);
    endtask

    initial begin
        idle_inputs();
        bus.imem_rdata = 32'h1111_1111;
        bus2.stall = 0; bus2.jump = 0; bus2.jump_addr_sel = 0; bus2.jump_index = '0;
        bus2.jr_addr = '0; bus2.branch_taken = 1; bus2.branch_target = 32'h100;
        bus2.imem_rdata = 32'hAAAA_AAAA;

        //   st j  s  idx          jr            br bt            rdata         fl pc            v  pc4           instr         cnt mis
        add(0, 0, 0, 26'h0,       32'h0,        0, 32'h0,         32'h1111_1111, 0, 32'h4,         1, 32'h4,         32'h1111_1111, 0, 0);
        add(0, 0, 0, 26'h0,       32'h0,        0, 32'h0,         32'h1111_1111, 0, 32'h8,         1, 32'h8,         32'h1111_1111, 0, 0);
        add(0, 0, 0, 26'h0,       32'h0,        1, 32'h4000_000C, 32'h1111_1111, 1, 32'h4000_000C, 0, 32'h8,         32'h0,         1, 0);
        add(0, 0, 0, 26'h0,       32'h0,        0, 32'h0,         32'h0800_0040, 0, 32'h4000_0010, 1, 32'h4000_0010, 32'h0800_0040, 1, 0);
        add(0, 1, 0, 26'h40,      32'h0,        0, 32'h0,         32'hDEAD_BEEF, 1, 32'h4000_0100, 0, 32'h4000_0010, 32'h0,         2, 0);
        add(0, 0, 0, 26'h0,       32'h0,        0, 32'h0,         32'h2222_2222, 0, 32'h4000_0104, 1, 32'h4000_0104, 32'h2222_2222, 2, 0);
        add(0, 1, 1, 26'h0,       32'h0000_2002, 0, 32'h0,        32'hDEAD_BEEF, 1, 32'h2000,      0, 32'h4000_0104, 32'h0,         3, 1);
        add(0, 0, 0, 26'h0,       32'h0,        0, 32'h0,         32'h3333_3333, 0, 32'h2004,      1, 32'h2004,      32'h3333_3333, 3, 0);
        add(0, 1, 0, 26'h3FF_FFFF, 32'h0,       1, 32'h80,        32'hDEAD_BEEF, 1, 32'h0FFF_FFFC, 0, 32'h2004,      32'h0,         4, 0);
        add(0, 0, 0, 26'h0,       32'h0,        0, 32'h0,         32'h4444_4444, 0, 32'h1000_0000, 1, 32'h1000_0000, 32'h4444_4444, 4, 0);
        add(0, 0, 1'bx, 26'h0,    32'h0,        1, 32'h80,        32'hDEAD_BEEF, 1, 32'h80,        0, 32'h1000_0000, 32'h0,         5, 0);
        add(0, 0, 0, 26'h0,       32'h0,        0, 32'h0,         32'h5555_5555, 0, 32'h84,        1, 32'h84,        32'h5555_5555, 5, 0);
        add(1, 1, 0, 26'h10,      32'h0,        0, 32'h0,         32'h9999_9999, 0, 32'h84,        1, 32'h84,        32'h5555_5555, 5, 0);
        add(1, 1, 0, 26'h10,      32'h0,        0, 32'h0,         32'h9999_9999, 0, 32'h84,        1, 32'h84,        32'h5555_5555, 5, 0);
        add(1, 1, 0, 26'h10,      32'h0,        0, 32'h0,         32'h9999_9999, 0, 32'h84,        1, 32'h84,        32'h5555_5555, 5, 0);
        add(0, 1, 0, 26'h10,      32'h0,        0, 32'h0,         32'h9999_9999, 1, 32'h40,        0, 32'h84,        32'h0,         6, 0);
        add(0, 1, 0, 26'h20,      32'h0,        0, 32'h0,         32'h6666_6666, 0, 32'h44,        1, 32'h44,        32'h6666_6666, 6, 0);
        add(0, 0, 0, 26'h0,       32'h0,        1, 32'hFFFF_FFFC, 32'hDEAD_BEEF, 1, 32'hFFFF_FFFC, 0, 32'h44,        32'h0,         7, 0);
        add(0, 0, 0, 26'h0,       32'h0,        0, 32'h0,         32'h7777_7777, 0, 32'h0,         1, 32'h0,         32'h7777_7777, 7, 0);
        add(0, 1, 1, 26'h0,       32'h0000_3000, 0, 32'h0,        32'hDEAD_BEEF, 1, 32'h3000,      0, 32'h0,         32'h0,         8, 0);
        add(0, 0, 0, 26'h0,       32'h0,        0, 32'h0,         32'h8888_8888, 0, 32'h3004,      1, 32'h3004,      32'h8888_8888, 8, 0);
        add(0, 1, 1, 26'h0,       32'h0000_5001, 0, 32'h0,        32'hDEAD_BEEF, 1, 32'h5000,      0, 32'h3004,      32'h0,         9, 1);

        #1 rst = 1'b1;
        #1 chk_reset("reset");
        @(posedge clk); @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rel_imem_addr", bus.imem_addr, 32'h0);
        chk("rel_valid", {31'b0, bus.ifid_valid}, 32'h0);
        chk("rel_flush", {31'b0, bus.flush}, 32'h0);

        for (int i = 0; i < vq.size(); i++) begin
            bus.stall         = vq[i].stall;
            bus.jump          = vq[i].jump;
            bus.jump_addr_sel = vq[i].sel;
            bus.jump_index    = vq[i].idx;
            bus.jr_addr       = vq[i].jr;
            bus.branch_taken  = vq[i].br;
            bus.branch_target = vq[i].bt;
            bus.imem_rdata    = vq[i].rdata;
            #1;
            chk($sformatf("v%0d_flush", i), {31'b0, bus.flush}, {31'b0, vq[i].e_flush});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_pc", i), bus.imem_addr, vq[i].e_pc);
            chk($sformatf("v%0d_valid", i), {31'b0, bus.ifid_valid}, {31'b0, vq[i].e_valid});
            chk($sformatf("v%0d_pc4", i), bus.ifid_pc4, vq[i].e_pc4);
            chk($sformatf("v%0d_instr", i), bus.ifid_instr, vq[i].e_instr);
            chk($sformatf("v%0d_cnt", i), {16'b0, bus.squash_cnt}, {16'b0, vq[i].e_cnt});
            chk($sformatf("v%0d_mis", i), {31'b0, bus.misalign_err}, {31'b0, vq[i].e_mis});
        end

        // Misalign pulse must drop after one cycle; narrow counter must sit at max.
        chk("sat_cnt_a", {30'b0, bus2.squash_cnt}, 32'h3);
        idle_inputs();
        bus.imem_rdata = 32'hABCD_0123;
        @(posedge clk);
        #1;
        chk("mis_pulse_end", {31'b0, bus.misalign_err}, 32'h0);
        chk("post_pc", bus.imem_addr, 32'h5004);
        chk("sat_cnt_b", {30'b0, bus2.squash_cnt}, 32'h3);
        bus.jump = 1; bus.jump_addr_sel = 1; bus.jr_addr = 32'h0000_6003;
        @(posedge clk);
        #1;
        chk("mis_again", {31'b0, bus.misalign_err}, 32'h1);
        chk("cnt_again", {16'b0, bus.squash_cnt}, 32'd10);
        chk("sat_cnt_c", {30'b0, bus2.squash_cnt}, 32'h3);

        // Asynchronous reset while the misalign flag and counter are nonzero.
        #2 rst = 1'b1;
        #1 chk_reset("async");
        idle_inputs();
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("resume_valid0", {31'b0, bus.ifid_valid}, 32'h0);
        chk("resume_addr0", bus.imem_addr, 32'h0);
        @(posedge clk);
        #1;
        chk("resume_valid1", {31'b0, bus.ifid_valid}, 32'h1);
        chk("resume_pc4", bus.ifid_pc4, 32'h4);
        chk("resume_addr1", bus.imem_addr, 32'h4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
